// File: rtl/addr_seq_multi.sv
// rtl/addr_seq_multi.sv - multi-channel RAM read/write address sequencer with arbitration and abort
// Optional macro ASEQ_STRIDE_EN adds an 8-bit per-transfer address stride input.
module addr_seq_multi #(
    parameter  int NUM_CH = 3,
    parameter  int ADDR_W = 32,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CH_W-1:0]   ch_sel,
    input  logic [ADDR_W-1:0] offset,
    input  logic [ADDR_W-1:0] length,
    input  logic              abort,
    input  logic [NUM_CH-1:0] rd_pause,
    input  logic [NUM_CH-1:0] wr_pause,
`ifdef ASEQ_STRIDE_EN
    input  logic [7:0]        stride,
`endif
    output logic [ADDR_W-1:0] addr,
    output logic              addr_valid,
    output logic              addr_is_wr,
    output logic [CH_W-1:0]   addr_ch,
    output logic [NUM_CH-1:0] rd_done,
    output logic [NUM_CH-1:0] wr_done,
    output logic              busy,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    localparam logic [CH_W:0]   NUM_CH_L = (CH_W + 1)'(NUM_CH);
    localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);

    state_e              state_q;
    logic [CH_W-1:0]     ch_q;
    logic [ADDR_W-1:0]   len_q;
    logic [ADDR_W-1:0]   rd_cnt_q;
    logic [ADDR_W-1:0]   wr_cnt_q;
    logic [ADDR_W-1:0]   rd_addr_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic                last_wr_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                addr_valid_q;
    logic                addr_is_wr_q;
    logic [CH_W-1:0]     addr_ch_q;
    logic [NUM_CH-1:0]   rd_done_q;
    logic [NUM_CH-1:0]   wr_done_q;
    logic                busy_q;
    logic                err_q;

    logic [ADDR_W-1:0]   step;
`ifdef ASEQ_STRIDE_EN
    logic [7:0]          stride_q;
    assign step = ADDR_W'(stride_q);
`else
    assign step = ONE;
`endif

    logic                rd_elig;
    logic                wr_elig;
    logic                contested;
    logic                grant_rd;
    logic                grant_wr;
    logic                ch_bad;
    logic [NUM_CH-1:0]   sel_bit;
    logic [ADDR_W-1:0]   rd_cnt_d;
    logic [ADDR_W-1:0]   wr_cnt_d;

    // A write may only reuse a word that has already been read out.
    assign rd_elig   = (state_q == RUN) && !rd_pause[ch_q] && (rd_cnt_q < len_q);
    assign wr_elig   = (state_q == RUN) && !wr_pause[ch_q] && (wr_cnt_q < len_q)
                       && (wr_cnt_q < rd_cnt_q);
    assign contested = rd_elig && wr_elig;
    assign grant_rd  = rd_elig && (!wr_elig || last_wr_q);
    assign grant_wr  = wr_elig && (!rd_elig || !last_wr_q);

    assign ch_bad    = ({1'b0, ch_sel} >= NUM_CH_L);
    assign sel_bit   = NUM_CH'(1) << ch_sel;
    assign rd_cnt_d  = rd_cnt_q + ONE;
    assign wr_cnt_d  = wr_cnt_q + ONE;

    // last_wr_q only records the winner of contested cycles, and each transfer
    // starts arbitration fresh so streams are independent of history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ch_q         <= '0;
            len_q        <= '0;
            rd_cnt_q     <= '0;
            wr_cnt_q     <= '0;
            rd_addr_q    <= '0;
            wr_addr_q    <= '0;
            last_wr_q    <= 1'b1;
            addr_q       <= '0;
            addr_valid_q <= 1'b0;
            addr_is_wr_q <= 1'b0;
            addr_ch_q    <= '0;
            rd_done_q    <= '0;
            wr_done_q    <= '0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
`ifdef ASEQ_STRIDE_EN
            stride_q     <= 8'd1;
`endif
        end else begin
            err_q        <= 1'b0;
            addr_valid_q <= 1'b0;
            if (abort) begin
                state_q   <= IDLE;
                busy_q    <= 1'b0;
                rd_done_q <= '0;
                wr_done_q <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start && ch_bad) begin
                            err_q <= 1'b1;
                        end else if (start) begin
                            ch_q      <= ch_sel;
                            len_q     <= length;
                            rd_cnt_q  <= '0;
                            wr_cnt_q  <= '0;
                            rd_addr_q <= offset;
                            wr_addr_q <= offset;
                            last_wr_q <= 1'b1;
                            busy_q    <= 1'b1;
`ifdef ASEQ_STRIDE_EN
                            stride_q  <= (stride == 8'd0) ? 8'd1 : stride;
`endif
                            if (length == '0) begin
                                state_q   <= DONE;
                                rd_done_q <= sel_bit;
                                wr_done_q <= sel_bit;
                            end else begin
                                state_q   <= RUN;
                                rd_done_q <= '0;
                                wr_done_q <= '0;
                            end
                        end
                    end
                    RUN: begin
                        if (rd_done_q[ch_q] && wr_done_q[ch_q]) begin
                            state_q <= DONE;
                        end else if (grant_rd) begin
                            addr_q       <= rd_addr_q;
                            addr_valid_q <= 1'b1;
                            addr_is_wr_q <= 1'b0;
                            addr_ch_q    <= ch_q;
                            rd_cnt_q     <= rd_cnt_d;
                            rd_addr_q    <= rd_addr_q + step;
                            if (contested) last_wr_q <= 1'b0;
                            if (rd_cnt_d == len_q) rd_done_q[ch_q] <= 1'b1;
                        end else if (grant_wr) begin
                            addr_q       <= wr_addr_q;
                            addr_valid_q <= 1'b1;
                            addr_is_wr_q <= 1'b1;
                            addr_ch_q    <= ch_q;
                            wr_cnt_q     <= wr_cnt_d;
                            wr_addr_q    <= wr_addr_q + step;
                            if (contested) last_wr_q <= 1'b1;
                            if (wr_cnt_d == len_q) wr_done_q[ch_q] <= 1'b1;
                        end
                    end
                    DONE: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign addr       = addr_q;
    assign addr_valid = addr_valid_q;
    assign addr_is_wr = addr_is_wr_q;
    assign addr_ch    = addr_ch_q;
    assign rd_done    = rd_done_q;
    assign wr_done    = wr_done_q;
    assign busy       = busy_q;
    assign err        = err_q;

endmodule

// File: tb/tb_addr_seq_multi.sv
// tb/tb_addr_seq_multi.sv - randomized self-checking bench for addr_seq_multi
// Compares every cycle against a count-and-multiply reference model of the sequencer.
module tb_addr_seq_multi;
    localparam int NUM_CH = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  ch_sel;
    logic [31:0] offset;
    logic [31:0] length;
    logic        abort;
    logic [2:0]  rd_pause;
    logic [2:0]  wr_pause;
`ifdef ASEQ_STRIDE_EN
    logic [7:0]  stride;
`endif
    logic [31:0] addr;
    logic        addr_valid;
    logic        addr_is_wr;
    logic [1:0]  addr_ch;
    logic [2:0]  rd_done;
    logic [2:0]  wr_done;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;

    addr_seq_multi #(.NUM_CH(3), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ch_sel(ch_sel),
        .offset(offset), .length(length), .abort(abort),
        .rd_pause(rd_pause), .wr_pause(wr_pause),
`ifdef ASEQ_STRIDE_EN
        .stride(stride),
`endif
        .addr(addr), .addr_valid(addr_valid), .addr_is_wr(addr_is_wr),
        .addr_ch(addr_ch), .rd_done(rd_done), .wr_done(wr_done),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Reference model: 0 idle, 1 running, 2 done
    int          m_state;
    int          m_ch;
    longint      m_off, m_len, m_rdc, m_wrc, m_stride;
    bit          m_last_wr;
    logic [31:0] m_addr;
    logic        m_valid, m_is_wr, m_busy, m_err;
    logic [1:0]  m_addr_ch;
    logic [2:0]  m_rd_done, m_wr_done;

    task automatic model_reset();
        m_state = 0; m_ch = 0; m_off = 0; m_len = 0; m_rdc = 0; m_wrc = 0;
        m_stride = 1; m_last_wr = 1'b1; m_addr = '0; m_valid = 1'b0;
        m_is_wr = 1'b0; m_busy = 1'b0; m_err = 1'b0; m_addr_ch = '0;
        m_rd_done = '0; m_wr_done = '0;
    endtask

    task automatic model_step();
        bit re, we, gw;
        m_err = 1'b0;
        m_valid = 1'b0;
        if (abort) begin
            m_state = 0; m_busy = 1'b0; m_rd_done = '0; m_wr_done = '0;
        end else if (m_state == 0) begin
            if (start && int'(ch_sel) >= NUM_CH) begin
                m_err = 1'b1;
            end else if (start) begin
                m_ch = int'(ch_sel); m_off = longint'(offset); m_len = longint'(length);
                m_rdc = 0; m_wrc = 0; m_last_wr = 1'b1; m_busy = 1'b1;
                m_rd_done = '0; m_wr_done = '0;
`ifdef ASEQ_STRIDE_EN
                m_stride = (stride == 8'd0) ? 1 : longint'(stride);
`else
                m_stride = 1;
`endif
                if (m_len == 0) begin
                    m_state = 2; m_rd_done[m_ch] = 1'b1; m_wr_done[m_ch] = 1'b1;
                end else begin
                    m_state = 1;
                end
            end
        end else if (m_state == 1) begin
            if (m_rd_done[m_ch] && m_wr_done[m_ch]) begin
                m_state = 2;
            end else begin
                re = !rd_pause[m_ch] && (m_rdc < m_len);
                we = !wr_pause[m_ch] && (m_wrc < m_len) && (m_wrc < m_rdc);
                if (re && we) begin
                    gw = !m_last_wr;
                    m_last_wr = gw;
                end else begin
                    gw = we;
                end
                if (re || we) begin
                    m_valid = 1'b1; m_is_wr = gw; m_addr_ch = 2'(m_ch);
                    if (gw) begin
                        m_addr = 32'(m_off + m_wrc * m_stride);
                        m_wrc++;
                        if (m_wrc == m_len) m_wr_done[m_ch] = 1'b1;
                    end else begin
                        m_addr = 32'(m_off + m_rdc * m_stride);
                        m_rdc++;
                        if (m_rdc == m_len) m_rd_done[m_ch] = 1'b1;
                    end
                end
            end
        end else begin
            m_state = 0; m_busy = 1'b0;
        end
    endtask

    function automatic logic [43:0] obs_vec();
        return {addr_valid, addr_is_wr, addr, addr_ch, rd_done, wr_done, busy, err};
    endfunction

    function automatic logic [43:0] exp_vec();
        return {m_valid, m_is_wr, m_addr, m_addr_ch, m_rd_done, m_wr_done, m_busy, m_err};
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        start = 1'b0; abort = 1'b0; ch_sel = '0; offset = '0; length = '0;
        rd_pause = '0; wr_pause = '0;
`ifdef ASEQ_STRIDE_EN
        stride = 8'd1;
`endif
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (!busy && m_state == 0) break;
            tick();
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL drain_cycle%0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
            checks++;
        end
        if (busy !== 1'b0) begin
            errors++; $display("FAIL drain_timeout: busy=%b expected 0", busy);
        end
        checks++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_idle();
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        if (obs_vec() !== 44'h0) begin
            errors++; $display("FAIL reset_outputs: got %h expected 0", obs_vec());
        end
        checks++;
    endtask

    task automatic test_basic();
        logic [32:0] got[$];
        logic [32:0] want[6];
        logic        busy_hist[12];
        int          w_idx = -1;
        want = '{33'h000000100, 33'h000000101, 33'h100000100,
                 33'h000000102, 33'h100000101, 33'h100000102};
        ch_sel = 2'd1; offset = 32'h100; length = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            busy_hist[i] = busy;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL basic_cycle%0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
            checks++;
            if (addr_valid === 1'b1) begin
                got.push_back({addr_is_wr, addr});
                if (addr_is_wr === 1'b0 && addr === 32'h102) begin
                    if (rd_done[1] !== 1'b1) begin
                        errors++; $display("FAIL basic_rd_done_with_last: got %b expected 1", rd_done[1]);
                    end
                    checks++;
                end
                if (addr_is_wr === 1'b1 && addr === 32'h102) begin
                    w_idx = i;
                    if (wr_done[1] !== 1'b1) begin
                        errors++; $display("FAIL basic_wr_done_with_last: got %b expected 1", wr_done[1]);
                    end
                    checks++;
                end
            end
        end
        if (got.size() !== 6) begin
            errors++; $display("FAIL basic_count: got %0d addresses expected 6", got.size());
        end
        checks++;
        for (int k = 0; k < 6 && k < got.size(); k++) begin
            if (got[k] !== want[k]) begin
                errors++; $display("FAIL basic_seq%0d: got %h expected %h", k, got[k], want[k]);
            end
            checks++;
        end
        if (w_idx < 0 || w_idx > 9) begin
            errors++; $display("FAIL basic_last_write: index %0d expected within window", w_idx);
        end else begin
            if (busy_hist[w_idx + 1] !== 1'b1 || busy_hist[w_idx + 2] !== 1'b0) begin
                errors++; $display("FAIL basic_busy_fall: got %b%b expected 10",
                                   busy_hist[w_idx + 1], busy_hist[w_idx + 2]);
            end
        end
        checks++;
        drain();
    endtask

    task automatic test_pause();
        ch_sel = 2'd0; offset = $urandom; length = 32'd6; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 24; i++) begin
            rd_pause = {2'($urandom_range(0, 3)), (i < 4)};
            wr_pause = {2'($urandom_range(0, 3)), (i >= 4 && i < 8)};
            tick();
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL pause_cycle%0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
            checks++;
            if (i < 4) begin
                if (addr_valid !== 1'b0) begin
                    errors++; $display("FAIL pause_rd_blocked%0d: valid=%b expected 0", i, addr_valid);
                end
                checks++;
            end else if (i < 8) begin
                if (addr_valid !== 1'b1 || addr_is_wr !== 1'b0) begin
                    errors++; $display("FAIL pause_reads_only%0d: valid=%b wr=%b expected 1 0",
                                       i, addr_valid, addr_is_wr);
                end
                checks++;
            end
        end
        rd_pause = '0; wr_pause = '0;
        drain();
    endtask

    task automatic test_zero_len();
        ch_sel = 2'd2; offset = $urandom; length = 32'd0; start = 1'b1;
        tick();
        start = 1'b0;
        if (rd_done !== 3'b100 || wr_done !== 3'b100 || addr_valid !== 1'b0) begin
            errors++; $display("FAIL zero_len_done: rd=%b wr=%b valid=%b expected 100 100 0",
                               rd_done, wr_done, addr_valid);
        end
        checks++;
        tick();
        if (obs_vec() !== exp_vec() || busy !== 1'b0) begin
            errors++; $display("FAIL zero_len_idle: got %h expected %h", obs_vec(), exp_vec());
        end
        checks++;
        drain();
    endtask

    task automatic test_wrap();
        logic [31:0] reads[$];
        logic [31:0] want[3];
        want = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000};
        ch_sel = 2'd1; offset = 32'hFFFF_FFFE; length = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL wrap_cycle%0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
            checks++;
            if (addr_valid === 1'b1 && addr_is_wr === 1'b0) reads.push_back(addr);
        end
        for (int k = 0; k < 3; k++) begin
            if (k >= reads.size() || reads[k] !== want[k]) begin
                errors++; $display("FAIL wrap_read%0d: got %h expected %h",
                                   k, (k < reads.size()) ? reads[k] : 32'hx, want[k]);
            end
            checks++;
        end
        drain();
    endtask

    task automatic test_bad_start();
        ch_sel = 2'd3; offset = $urandom; length = 32'd4; start = 1'b1;
        tick();
        start = 1'b0;
        if (err !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL bad_start_err: err=%b busy=%b expected 1 0", err, busy);
        end
        checks++;
        tick();
        if (err !== 1'b0 || obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL bad_start_after: got %h expected %h", obs_vec(), exp_vec());
        end
        checks++;
    endtask

    task automatic test_start_busy();
        ch_sel = 2'd1; offset = 32'h200; length = 32'd4; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        ch_sel = 2'd3; offset = 32'h900; length = 32'd1; start = 1'b1;
        tick();
        start = 1'b0;
        if (err !== 1'b0 || busy !== 1'b1 || obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL start_while_busy: got %h expected %h", obs_vec(), exp_vec());
        end
        checks++;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL busy_run_cycle%0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
            checks++;
        end
        drain();
    endtask

    task automatic test_abort();
        int n = 0;
        logic [32:0] got[$];
        logic [32:0] want[4];
        want = '{33'h000000010, 33'h000000011, 33'h100000010, 33'h100000011};
        ch_sel = 2'd2; offset = $urandom; length = 32'd5; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20 && n < 2; i++) begin
            tick();
            if (addr_valid === 1'b1) n++;
        end
        if (n < 2) begin
            errors++; $display("FAIL abort_setup: got %0d addresses expected 2", n);
        end
        checks++;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        if (addr_valid !== 1'b0 || busy !== 1'b0 || rd_done !== 3'b000 || wr_done !== 3'b000) begin
            errors++; $display("FAIL abort_effect: valid=%b busy=%b rd=%b wr=%b expected 0 0 000 000",
                               addr_valid, busy, rd_done, wr_done);
        end
        checks++;
        ch_sel = 2'd0; offset = 32'h10; length = 32'd2; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL abort_restart%0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
            checks++;
            if (addr_valid === 1'b1) got.push_back({addr_is_wr, addr});
        end
        for (int k = 0; k < 4; k++) begin
            if (k >= got.size() || got[k] !== want[k]) begin
                errors++; $display("FAIL abort_restart_seq%0d: got %h expected %h",
                                   k, (k < got.size()) ? got[k] : 33'hx, want[k]);
            end
            checks++;
        end
        if (rd_done !== 3'b001 || wr_done !== 3'b001) begin
            errors++; $display("FAIL abort_restart_done: rd=%b wr=%b expected 001 001", rd_done, wr_done);
        end
        checks++;
        drain();
    endtask

`ifdef ASEQ_STRIDE_EN
    task automatic test_stride();
        logic [32:0] got[$];
        logic [32:0] want[4];
        want = '{33'h000000040, 33'h000000044, 33'h100000040, 33'h100000044};
        ch_sel = 2'd1; offset = 32'h40; length = 32'd2; stride = 8'd4; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (addr_valid === 1'b1) got.push_back({addr_is_wr, addr});
        end
        for (int k = 0; k < 4; k++) begin
            if (k >= got.size() || got[k] !== want[k]) begin
                errors++; $display("FAIL stride_seq%0d: got %h expected %h",
                                   k, (k < got.size()) ? got[k] : 33'hx, want[k]);
            end
            checks++;
        end
        drain();
    endtask
`endif

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 40; i++) begin
                start  = ($urandom_range(0, 7) == 0);
                ch_sel = 2'($urandom_range(0, 3));
                offset = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                     : $urandom;
                length = 32'($urandom_range(0, 6));
                abort  = ($urandom_range(0, 49) == 0);
                rd_pause = 3'($urandom) & 3'($urandom);
                wr_pause = 3'($urandom) & 3'($urandom);
`ifdef ASEQ_STRIDE_EN
                stride = 8'($urandom_range(0, 255));
`endif
                tick();
                if (obs_vec() !== exp_vec()) begin
                    errors++; $display("FAIL random_t%0d_c%0d: got %h expected %h", t, i, obs_vec(), exp_vec());
                end
                checks++;
            end
        end
        set_idle();
        drain();
    endtask

    task automatic test_async_reset();
        ch_sel = 2'd1; offset = 32'h300; length = 32'd5; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        if (obs_vec() !== 44'h0) begin
            errors++; $display("FAIL async_reset: got %h expected 0", obs_vec());
        end
        checks++;
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL async_reset_release: got %h expected %h", obs_vec(), exp_vec());
        end
        checks++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_pause();
        test_zero_len();
        test_wrap();
        test_bad_start();
        test_start_busy();
        test_abort();
`ifdef ASEQ_STRIDE_EN
        test_stride();
`endif
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
